// File: rtl/access_keypad_entry_if.sv
// Keypad / comparator / door signals for the access keypad front end.
// master is the keypad+comparator side, slave is the keypad controller.
interface access_keypad_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        door_match;
  logic        emergency;
  logic [11:0] access_code;
  logic        code_valid;
  logic        door_unlock;
  logic        locked;
  logic        alarm;
  logic [2:0]  digit_count;

  modport master (
    output key_valid, key_code, door_match, emergency,
    input  access_code, code_valid, door_unlock, locked, alarm, digit_count
  );

  modport slave (
    input  key_valid, key_code, door_match, emergency,
    output access_code, code_valid, door_unlock, locked, alarm, digit_count
  );
endinterface

// File: rtl/access_keypad_entry.sv
// Keypad entry controller: decimal digits -> 12-bit code, match check,
// door-open timing, failed-attempt lockout and emergency override.
module access_keypad_entry #(
  parameter int NUM_DIGITS       = 3,
  parameter int ENTRY_TIMEOUT    = 1000,
  parameter int MAX_ATTEMPTS     = 3,
  parameter int LOCKOUT_CYCLES   = 5000,
  parameter int DOOR_OPEN_CYCLES = 2000
) (
  input  logic clk,
  input  logic rst_n,
  access_keypad_entry_if.slave bus
);
  localparam int ET_W = $clog2(ENTRY_TIMEOUT + 1);
  localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam int OP_W = $clog2(DOOR_OPEN_CYCLES + 1);
  localparam int FC_W = $clog2(MAX_ATTEMPTS + 1);
  localparam logic [ET_W-1:0] ET_LAST = ET_W'(ENTRY_TIMEOUT - 1);
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [OP_W-1:0] OP_LAST = OP_W'(DOOR_OPEN_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(MAX_ATTEMPTS - 1);
  localparam logic [2:0]      ND      = 3'(NUM_DIGITS);

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, LOCKOUT} state_t;

  state_t            state;
  logic [11:0]       acc, code;
  logic              ovf, cv, unlock, lock_r;
  logic [2:0]        dcnt;
  logic [FC_W-1:0]   fail_cnt;
  logic [ET_W-1:0]   t_entry;
  logic [LK_W-1:0]   t_lock;
  logic [OP_W-1:0]   t_open;
  logic              is_digit;
  logic [13:0]       acc_next;

  assign is_digit = (bus.key_code <= 4'd9);
  // NUM_DIGITS <= 4 keeps acc*10+digit within 14 bits before saturation
  assign acc_next = {2'b00, acc} * 14'd10 + {10'd0, bus.key_code};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      code     <= '0;
      ovf      <= 1'b0;
      cv       <= 1'b0;
      unlock   <= 1'b0;
      lock_r   <= 1'b0;
      dcnt     <= '0;
      fail_cnt <= '0;
      t_entry  <= '0;
      t_lock   <= '0;
      t_open   <= '0;
    end else if (bus.emergency) begin
      state    <= IDLE;
      acc      <= '0;
      ovf      <= 1'b0;
      dcnt     <= '0;
      fail_cnt <= '0;
      t_entry  <= '0;
      t_lock   <= '0;
      t_open   <= '0;
      lock_r   <= 1'b0;
      cv       <= 1'b0;
      unlock   <= 1'b1;
    end else begin
      cv     <= 1'b0;
      unlock <= 1'b0;
      case (state)
        IDLE: if (bus.key_valid && is_digit) begin
          acc     <= {8'd0, bus.key_code};
          dcnt    <= 3'd1;
          ovf     <= 1'b0;
          t_entry <= '0;
          state   <= ENTRY;
        end
        ENTRY: if (bus.key_valid) begin
          t_entry <= '0;
          if (is_digit) begin
            if (dcnt < ND) begin
              if (acc_next > 14'd4095) begin
                ovf <= 1'b1;
                acc <= 12'hFFF;
              end else begin
                acc <= acc_next[11:0];
              end
              dcnt <= dcnt + 3'd1;
            end
          end else if (bus.key_code == 4'd10) begin
            acc   <= '0;
            dcnt  <= '0;
            ovf   <= 1'b0;
            state <= IDLE;
          end else if (bus.key_code == 4'd11) begin
            if (ovf) begin
              // overflowed entry is a failed attempt with no code presented
              acc  <= '0;
              dcnt <= '0;
              ovf  <= 1'b0;
              if (fail_cnt == FC_LAST) begin
                fail_cnt <= '0;
                lock_r   <= 1'b1;
                t_lock   <= '0;
                state    <= LOCKOUT;
              end else begin
                fail_cnt <= fail_cnt + 1'b1;
                state    <= IDLE;
              end
            end else begin
              code  <= acc;
              cv    <= 1'b1;
              state <= CHECK;
            end
          end
        end else if (t_entry == ET_LAST) begin
          acc   <= '0;
          dcnt  <= '0;
          ovf   <= 1'b0;
          state <= IDLE;
        end else begin
          t_entry <= t_entry + 1'b1;
        end
        CHECK: begin
          acc  <= '0;
          dcnt <= '0;
          ovf  <= 1'b0;
          if (bus.door_match) begin
            fail_cnt <= '0;
            unlock   <= 1'b1;
            t_open   <= '0;
            state    <= OPEN;
          end else if (fail_cnt == FC_LAST) begin
            fail_cnt <= '0;
            lock_r   <= 1'b1;
            t_lock   <= '0;
            state    <= LOCKOUT;
          end else begin
            fail_cnt <= fail_cnt + 1'b1;
            state    <= IDLE;
          end
        end
        OPEN: if (t_open == OP_LAST) begin
          state <= IDLE;
        end else begin
          unlock <= 1'b1;
          t_open <= t_open + 1'b1;
        end
        LOCKOUT: if (t_lock == LK_LAST) begin
          lock_r <= 1'b0;
          state  <= IDLE;
        end else begin
          t_lock <= t_lock + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.access_code = code;
  assign bus.code_valid  = cv;
  assign bus.door_unlock = unlock;
  assign bus.locked      = lock_r;
  assign bus.alarm       = lock_r;
  assign bus.digit_count = dcnt;
endmodule

// File: tb/tb_access_keypad_entry.sv
// Directed + randomized bench for access_keypad_entry against a
// queue-based reference model of the keypad rules.
module tb_access_keypad_entry;
  localparam int ND = 4, ET = 10, MA = 3, LC = 16, DC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   target = 0;
  int   n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  access_keypad_entry_if bus();
  assign bus.door_match = (int'(bus.access_code) == target);

  access_keypad_entry #(
    .NUM_DIGITS(ND), .ENTRY_TIMEOUT(ET), .MAX_ATTEMPTS(MA),
    .LOCKOUT_CYCLES(LC), .DOOR_OPEN_CYCLES(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // reference model: digits held as a list, timing as countdowns
  int digs[$];
  bit entering, checking, m_unlock;
  int idle_cnt, fails, open_left, lock_left, m_code;

  function automatic int mval();
    int v = 0;
    foreach (digs[i]) v = v * 10 + digs[i];
    return v;
  endfunction

  function void m_fail();
    fails++;
    if (fails == MA) begin
      fails = 0;
      lock_left = LC;
    end
    digs.delete();
    entering = 0;
  endfunction

  always @(posedge clk) begin
    int k;
    bit kv;
    kv = bus.key_valid;
    k  = int'(bus.key_code);
    if (!rst_n) begin
      digs.delete(); entering = 0; checking = 0; idle_cnt = 0; fails = 0;
      open_left = 0; lock_left = 0; m_code = 0; m_unlock = 0;
    end else if (bus.emergency) begin
      digs.delete(); entering = 0; checking = 0; idle_cnt = 0; fails = 0;
      open_left = 0; lock_left = 0; m_unlock = 1;
    end else begin
      if (checking) begin
        checking = 0;
        digs.delete();
        entering = 0;
        if (m_code == target) begin
          fails = 0;
          open_left = DC;
        end else m_fail();
      end else if (open_left > 0) open_left--;
      else if (lock_left > 0) lock_left--;
      else if (!entering) begin
        if (kv && k <= 9) begin
          digs.push_back(k);
          entering = 1;
          idle_cnt = 0;
        end
      end else if (kv) begin
        idle_cnt = 0;
        if (k <= 9) begin
          if (digs.size() < ND) digs.push_back(k);
        end else if (k == 10) begin
          digs.delete();
          entering = 0;
        end else if (k == 11) begin
          if (mval() > 4095) m_fail();
          else begin
            m_code = mval();
            checking = 1;
          end
        end
      end else begin
        idle_cnt++;
        if (idle_cnt == ET) begin
          digs.delete();
          entering = 0;
        end
      end
      m_unlock = (open_left > 0);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("access_code", int'(bus.access_code), m_code);
    chk("code_valid",  int'(bus.code_valid),  int'(checking));
    chk("door_unlock", int'(bus.door_unlock), int'(m_unlock));
    chk("locked",      int'(bus.locked),      int'(lock_left > 0));
    chk("alarm",       int'(bus.alarm),       int'(lock_left > 0));
    chk("digit_count", int'(bus.digit_count), digs.size());
  endtask

  // drive inputs at the negedge, compare at the following negedge
  task automatic step(input bit kv, input int kc);
    bus.key_valid = kv;
    bus.key_code  = 4'(kc);
    @(negedge clk);
    check_outputs();
    bus.key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0);
  endtask

  task automatic press(input int kc);
    step(1, kc);
    idle($urandom_range(0, 2));
  endtask

  task automatic enter_code(input int a, input int b, input int c);
    press(a); press(b); press(c); press(11);
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    bus.emergency = 1'b0;
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;

    // correct code opens the door
    target = 731;
    enter_code(7, 3, 1);
    idle(DC + 3);

    // three misses -> lockout; keys during lockout ignored
    target = 294;
    repeat (3) begin
      enter_code(1, 2, 3);
      idle(2);
    end
    enter_code(7, 3, 1);
    idle(LC);
    enter_code(2, 9, 4);
    idle(DC + 3);

    // four-digit overflow is a silent failure; 2945 fits
    press(9); press(9); press(9); press(9); press(11);
    idle(2);
    target = 2945;
    press(2); press(9); press(4); press(5); press(11);
    idle(DC + 3);

    // timeout discards, then clear mid-entry
    press(2); press(9);
    idle(ET + 2);
    target = 191;
    press(3); press(10); press(1); press(9); press(1); press(11);
    idle(DC + 3);

    // emergency during lockout
    target = 337;
    repeat (3) begin
      enter_code(1, 1, 1);
      idle(1);
    end
    idle(3);
    bus.emergency = 1'b1;
    idle(5);
    bus.emergency = 1'b0;
    idle(2);
    enter_code(3, 3, 7);
    idle(DC + 3);

    // reset in the middle of OPEN
    target = 5;
    step(1, 5);
    step(1, 11);
    idle(4);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(3);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55) press($urandom_range(0, 9));
      else if (r < 62) press(10);
      else if (r < 78) begin
        target = ($urandom_range(0, 1) == 1) ? mval() : $urandom_range(0, 4095);
        press(11);
      end else if (r < 82) press($urandom_range(12, 15));
      else if (r < 87) begin
        bus.emergency = 1'b1;
        repeat ($urandom_range(1, 4)) step($urandom_range(0, 1), $urandom_range(0, 15));
        bus.emergency = 1'b0;
      end else if (r < 92) idle(ET + 2);
      else if (r < 94) begin
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
      end else idle($urandom_range(1, 20));
    end
    idle(LC + DC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
